// File: rtl/apsk_frame_sequencer.sv
// Merges header and payload streams into one modulator frame, tagging each word with its bits-per-symbol.
// Define APSK_FRAME_SEQUENCER_PILOT_EN to insert periodic pilot blocks into the payload.
module apsk_frame_sequencer #(
  parameter int DATA_WIDTH                  = 32,
  parameter int HEADER_WORDS                = 3,
  parameter int MAX_PAYLOAD_WORDS           = 4096,
  parameter int PILOT_PERIOD                = 16,
  parameter int PILOT_WORDS                 = 1,
  parameter logic [DATA_WIDTH-1:0] PILOT_WORD = 32'hA5A5_A5A5
) (
  input  logic                                    aclk,
  input  logic                                    reset,
  output logic                                    header_in_tready,
  input  logic [DATA_WIDTH-1:0]                   header_in_tdata,
  input  logic                                    header_in_tlast,
  input  logic                                    header_in_tvalid,
  output logic                                    payload_in_tready,
  input  logic [DATA_WIDTH-1:0]                   payload_in_tdata,
  input  logic                                    payload_in_tlast,
  input  logic                                    payload_in_tvalid,
  input  logic                                    data_out_tready,
  output logic [DATA_WIDTH-1:0]                   data_out_tdata,
  output logic [3:0]                              data_out_tuser,
  output logic                                    data_out_tlast,
  output logic                                    data_out_tvalid,
  input  logic [3:0]                              header_bits_per_symbol,
  input  logic [3:0]                              payload_bits_per_symbol,
  input  logic [$clog2(MAX_PAYLOAD_WORDS+1)-1:0]  payload_words,
  input  logic                                    modulator_done,
  output logic                                    busy,
  output logic [15:0]                             frame_count,
  output logic [2:0]                              error
);

  localparam int LEN_W = $clog2(MAX_PAYLOAD_WORDS + 1);
  localparam int HC_W  = $clog2(HEADER_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
    S_PILOT,
`endif
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]  pay_cnt_q, pay_cnt_d;
  logic [LEN_W-1:0]  pay_len_q, pay_len_d;
  logic [3:0]        hdr_bps_q, hdr_bps_d;
  logic [3:0]        pay_bps_q, pay_bps_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [2:0]        error_q, error_d;
  logic              hdr_last;
  logic              pay_last;

`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
  localparam int PC_W = $clog2(PILOT_PERIOD + 1);
  localparam int PW_W = $clog2(PILOT_WORDS + 1);
  logic [PC_W-1:0]   per_cnt_q, per_cnt_d;
  logic [PW_W-1:0]   pw_cnt_q, pw_cnt_d;
`endif

  // Out-of-range modulation orders fall back to BPSK so the modulator never sees an illegal tuser.
  function automatic logic [3:0] legal_bps(input logic [3:0] b);
    return (b == 4'd0 || b > 4'd8) ? 4'd1 : b;
  endfunction

  function automatic logic bad_bps(input logic [3:0] b);
    return (b == 4'd0 || b > 4'd8);
  endfunction

  assign hdr_last    = (hdr_cnt_q == HC_W'(HEADER_WORDS - 1));
  assign pay_last    = (pay_cnt_q == pay_len_q - LEN_W'(1));
  assign busy        = (state_q != S_IDLE);
  assign frame_count = frame_count_q;
  assign error       = error_q;

  always_comb begin
    state_d           = state_q;
    hdr_cnt_d         = hdr_cnt_q;
    pay_cnt_d         = pay_cnt_q;
    pay_len_d         = pay_len_q;
    hdr_bps_d         = hdr_bps_q;
    pay_bps_d         = pay_bps_q;
    frame_count_d     = frame_count_q;
    error_d           = error_q;
    header_in_tready  = 1'b0;
    payload_in_tready = 1'b0;
    data_out_tvalid   = 1'b0;
    data_out_tdata    = '0;
    data_out_tuser    = '0;
    data_out_tlast    = 1'b0;
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
    per_cnt_d         = per_cnt_q;
    pw_cnt_d          = pw_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (header_in_tvalid) begin
          hdr_bps_d = legal_bps(header_bits_per_symbol);
          pay_bps_d = legal_bps(payload_bits_per_symbol);
          if (payload_words > LEN_W'(MAX_PAYLOAD_WORDS)) begin
            pay_len_d  = LEN_W'(MAX_PAYLOAD_WORDS);
            error_d[2] = 1'b1;
          end else begin
            pay_len_d = payload_words;
          end
          if (bad_bps(header_bits_per_symbol) || bad_bps(payload_bits_per_symbol))
            error_d[2] = 1'b1;
          hdr_cnt_d = '0;
          pay_cnt_d = '0;
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
          per_cnt_d = '0;
          pw_cnt_d  = '0;
`endif
          state_d = S_HEADER;
        end
      end

      S_HEADER: begin
        header_in_tready = data_out_tready;
        data_out_tvalid  = header_in_tvalid;
        data_out_tdata   = header_in_tdata;
        data_out_tuser   = hdr_bps_q;
        data_out_tlast   = hdr_last && (pay_len_q == '0);
        if (header_in_tvalid && data_out_tready) begin
          if (header_in_tlast != hdr_last) error_d[0] = 1'b1;
          if (hdr_last) begin
            hdr_cnt_d = '0;
            state_d   = (pay_len_q == '0) ? S_DRAIN : S_PAYLOAD;
          end else begin
            hdr_cnt_d = hdr_cnt_q + HC_W'(1);
          end
        end
      end

      S_PAYLOAD: begin
        payload_in_tready = data_out_tready;
        data_out_tvalid   = payload_in_tvalid;
        data_out_tdata    = payload_in_tdata;
        data_out_tuser    = pay_bps_q;
        data_out_tlast    = pay_last;
        if (payload_in_tvalid && data_out_tready) begin
          if (payload_in_tlast != pay_last) error_d[1] = 1'b1;
          if (pay_last) begin
            pay_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            pay_cnt_d = pay_cnt_q + LEN_W'(1);
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
            // A pilot block never follows the final payload word.
            if (per_cnt_q == PC_W'(PILOT_PERIOD - 1)) begin
              per_cnt_d = '0;
              state_d   = S_PILOT;
            end else begin
              per_cnt_d = per_cnt_q + PC_W'(1);
            end
`endif
          end
        end
      end

`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
      S_PILOT: begin
        data_out_tvalid = 1'b1;
        data_out_tdata  = PILOT_WORD;
        data_out_tuser  = hdr_bps_q;
        if (data_out_tready) begin
          if (pw_cnt_q == PW_W'(PILOT_WORDS - 1)) begin
            pw_cnt_d = '0;
            state_d  = S_PAYLOAD;
          end else begin
            pw_cnt_d = pw_cnt_q + PW_W'(1);
          end
        end
      end
`endif

      S_DRAIN: begin
        if (modulator_done) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hdr_cnt_q     <= '0;
      pay_cnt_q     <= '0;
      pay_len_q     <= '0;
      hdr_bps_q     <= '0;
      pay_bps_q     <= '0;
      frame_count_q <= '0;
      error_q       <= '0;
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
      per_cnt_q     <= '0;
      pw_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      pay_cnt_q     <= pay_cnt_d;
      pay_len_q     <= pay_len_d;
      hdr_bps_q     <= hdr_bps_d;
      pay_bps_q     <= pay_bps_d;
      frame_count_q <= frame_count_d;
      error_q       <= error_d;
`ifdef APSK_FRAME_SEQUENCER_PILOT_EN
      per_cnt_q     <= per_cnt_d;
      pw_cnt_q      <= pw_cnt_d;
`endif
    end
  end

endmodule

// File: doc/apsk_frame_sequencer.md
# apsk_frame_sequencer

Frame-level controller placed directly upstream of `apsk_modulator`'s `data_in` AXI-Stream port. It merges a header stream and a payload stream into one modulator frame, tags every word with the bits-per-symbol the modulator must use for it, and generates the frame `tlast`. It holds off the next frame until the modulator reports the previous frame fully flushed through the pulse-shaping filters.

## Interface

Parameters
- `DATA_WIDTH`, 32: word width of all streams; must match the modulator `DATA_IN_TDATA_WIDTH`.
- `HEADER_WORDS`, 3: fixed number of header words per frame, ≥1.
- `MAX_PAYLOAD_WORDS`, 4096: upper bound on `payload_words`.
- `PILOT_PERIOD`, 16: payload words between pilot blocks (pilot build only).
- `PILOT_WORDS`, 1: words per pilot block (pilot build only).
- `PILOT_WORD`, 32'hA5A5_A5A5: constant pilot word (pilot build only).

Ports
- `aclk` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `header_in_tready` out 1; `header_in_tdata` in DATA_WIDTH; `header_in_tlast` in 1; `header_in_tvalid` in 1: header stream.
- `payload_in_tready` out 1; `payload_in_tdata` in DATA_WIDTH; `payload_in_tlast` in 1; `payload_in_tvalid` in 1: payload stream.
- `data_out_tready` in 1; `data_out_tdata` out DATA_WIDTH; `data_out_tuser` out 4 (bits per symbol for this word); `data_out_tlast` out 1; `data_out_tvalid` out 1: to the modulator.
- `header_bits_per_symbol` in 4; `payload_bits_per_symbol` in 4: sampled at frame start.
- `payload_words` in $clog2(MAX_PAYLOAD_WORDS+1): payload length, sampled at frame start.
- `modulator_done` in 1: single-cycle pulse, the modulator's `data_out_tlast` handshake.
- `busy` out 1: high in any state other than IDLE.
- `frame_count` out 16: completed frames, wraps 0xFFFF→0.
- `error` out 3: sticky; bit0 header tlast mismatch, bit1 payload tlast mismatch, bit2 illegal bits-per-symbol or length.

## Operation

- States: IDLE, HEADER, PAYLOAD, PILOT (pilot build only), DRAIN.
- IDLE: all treadys 0, `data_out_tvalid` 0. When `header_in_tvalid`=1, latch both bits-per-symbol values and `payload_words`, then go to HEADER. A bits-per-symbol value of 0 or >8 is latched as 1 and sets error bit2. `payload_words` > MAX is latched as MAX and sets error bit2.
- HEADER: `header_in` is routed combinationally to `data_out`, with `tuser`=header bps. A header word counter advances on each output handshake.
  - On word HEADER_WORDS-1, `header_in_tlast` must be 1; any other word must have it 0. A mismatch sets error bit0. The internal count always governs.
  - After the last header word: if the latched payload length is 0, that word carries `data_out_tlast`=1 and the FSM goes to DRAIN. Otherwise it goes to PAYLOAD.
- PAYLOAD: `payload_in` is routed to `data_out`, with `tuser`=payload bps. A payload counter advances on each handshake. The final word (count = latched length−1) carries `data_out_tlast`=1 and the FSM goes to DRAIN. `payload_in_tlast` is checked the same way as the header tlast and sets error bit1 on mismatch.
- DRAIN: all treadys 0. On `modulator_done`, increment `frame_count` and go to IDLE.
- Non-selected input tready is always 0. Input tlast is never forwarded.
- Reset in any state returns the FSM to IDLE, zeroes all counters and latches, and clears `error` and `frame_count`.

## Timing

- Zero-latency data path: `data_out_tvalid`/`tdata`/`tuser`/`tlast` are combinational from the selected source and the registered state. Selected `*_tready` = `data_out_tready`.
- State and counter changes occur on the clock edge of a completed handshake (`tvalid`&`tready`).
- IDLE→HEADER takes one cycle. The first header word can hand off in the cycle after `header_in_tvalid` is seen.
- `modulator_done` is ignored outside DRAIN. A pulse in the same cycle as the last-word handshake is also ignored; the FSM then waits for the next pulse.
- Reset values: all treadys 0, `data_out_tvalid` 0, `data_out_tlast` 0, `data_out_tdata` 0, `data_out_tuser` 0, `busy` 0, `frame_count` 0, `error` 0.

## Configuration

- `APSK_FRAME_SEQUENCER_PILOT_EN` defined:
  - In PAYLOAD, after every PILOT_PERIOD payload handshakes (and not after the final payload word), enter PILOT.
  - PILOT emits PILOT_WORDS words of PILOT_WORD with `tvalid`=1, `tuser`=header bps and `payload_in_tready`=0, then returns to PAYLOAD.
  - Pilots are not counted in the payload length.
- Undefined: the PILOT state and pilot counter are absent, and the payload is contiguous.

## Test plan

- Header 3 words, payload 5 words, bps 2/4, `tready` always 1 → 8 words out in order; `tuser` 2,2,2,4,4,4,4,4; `tlast` only on word 8; `busy` stays high until `modulator_done`, then `frame_count`=1.
- `payload_words`=0 → 3 header words out, `tlast` on word 3; no `payload_in_tready` pulse.
- Random `data_out_tready` backpressure with 50% duty → output identical to the stall-free case; no word dropped or duplicated.
- Header `tlast` asserted on word 2 of 3, payload bps=9 → `error`=3'b101; frame still 3+N words with `tuser` 1 on payload words.
- Reset asserted mid-PAYLOAD on word 3 → next cycle all outputs at reset values; a new frame then starts cleanly from its first header word.
- Pilot build, PILOT_PERIOD=2, PILOT_WORDS=1, payload 5 → output H,H,H,P,P,A5A5A5A5,P,P,A5A5A5A5,P; `tlast` on the last P.
